conv1d_ctrl_fsm: RTL and testbench



---
 rtl/conv1d_ctrl_pkg.sv | 8 +
 rtl/conv1d_loop_cnt.sv | 17 +
 rtl/conv1d_ctrl_fsm.sv | 101 ++++++++++
 tb/tb_conv1d_ctrl_fsm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv1d_ctrl_pkg.sv
// conv1d_ctrl_pkg: shared state and field types for the conv1d sequencer
package conv1d_ctrl_pkg;
  localparam int LEN_W_DEF = 16;
  localparam int K_W_DEF = 8;
  typedef logic [LEN_W_DEF-1:0] len_t;
  typedef logic [K_W_DEF-1:0] ksize_t;
  typedef enum logic [2:0] {IDLE, MAC, WAIT, OUT, DONE} ctrl_state_e;
endpackage

// File: rtl/conv1d_loop_cnt.sv
// conv1d_loop_cnt: up-counter that wraps to zero at its limit, with clear and terminal count
module conv1d_loop_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] lim_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);
  assign tc_o = cnt_o == lim_i;
  always_ff @(posedge clk_i)
    if (rst_i || clr_i) cnt_o <= '0;
    else if (en_i) cnt_o <= tc_o ? '0 : cnt_o + 1'b1;
endmodule

// File: rtl/conv1d_ctrl_fsm.sv
// conv1d_ctrl_fsm: address/MAC/output sequencer for valid-mode 1-D convolution
module conv1d_ctrl_fsm
  import conv1d_ctrl_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int K_W     = 8,
  parameter int MAC_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [K_W-1:0]   ksize_i,
  output logic [LEN_W-1:0] in_addr_o,
  output logic [K_W-1:0]   w_addr_o,
  output logic             mac_en_o,
  output logic             mac_clr_o,
  output logic             mac_last_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [LEN_W-1:0] out_addr_o,
  output logic             running_o,
  output logic             running_we_o,
  output logic             done_o,
  output logic             done_we_o
);
  localparam int DW = $clog2(MAC_LAT + 1);
  ctrl_state_e state;
  logic start_q, st_q, dn_q, cl_q;
  logic [LEN_W-1:0] n_q, j;
  logic [K_W-1:0] k_q, k;
  logic [DW-1:0] d_cnt_unused;
  logic k_tc, j_tc, d_tc, cnt_clr, start_edge, degen;
  assign cnt_clr = clear_i || state == IDLE;
  assign start_edge = start_i && !start_q;
  assign degen = ksize_i == '0 || LEN_W'(ksize_i) > len_i;
  conv1d_loop_cnt #(.W(K_W)) u_k (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .en_i(state == MAC),
    .lim_i(k_q - 1'b1), .cnt_o(k), .tc_o(k_tc)
  );
  conv1d_loop_cnt #(.W(LEN_W)) u_j (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .en_i(state == OUT && out_ready_i),
    .lim_i(n_q - LEN_W'(k_q)), .cnt_o(j), .tc_o(j_tc)
  );
  conv1d_loop_cnt #(.W(DW)) u_d (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .en_i(state == WAIT),
    .lim_i(DW'(MAC_LAT - 1)), .cnt_o(d_cnt_unused), .tc_o(d_tc)
  );
  // status pulses are registered so they line up with the first cycle of the new state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      start_q <= 1'b0;
      st_q <= 1'b0;
      dn_q <= 1'b0;
      cl_q <= 1'b0;
      n_q <= '0;
      k_q <= '0;
    end else begin
      start_q <= start_i;
      st_q <= 1'b0;
      dn_q <= 1'b0;
      cl_q <= 1'b0;
      if (clear_i) begin
        state <= IDLE;
        cl_q <= state != IDLE;
      end else begin
        case (state)
          IDLE: if (start_edge) begin
            n_q <= len_i;
            k_q <= ksize_i;
            st_q <= 1'b1;
            state <= degen ? DONE : MAC;
          end
          MAC: if (k_tc) state <= WAIT;
          WAIT: if (d_tc) state <= OUT;
          OUT: if (out_ready_i) begin
            state <= j_tc ? DONE : MAC;
            dn_q <= j_tc;
          end
          default: begin
            state <= IDLE;
            dn_q <= !dn_q;
          end
        endcase
      end
    end
  end
  assign mac_en_o = state == MAC;
  assign mac_clr_o = mac_en_o && k == '0;
  assign mac_last_o = mac_en_o && k_tc;
  assign in_addr_o = mac_en_o ? j + LEN_W'(k) : '0;
  assign w_addr_o = mac_en_o ? k : '0;
  assign out_valid_o = state == OUT;
  assign out_addr_o = out_valid_o ? j : '0;
  assign running_o = st_q;
  assign running_we_o = st_q || dn_q || cl_q;
  assign done_o = dn_q;
  assign done_we_o = st_q || dn_q;
endmodule

// File: tb/tb_conv1d_ctrl_fsm.sv
// tb_conv1d_ctrl_fsm: scenario tests of the conv1d sequencer against a loop-nest reference
module tb_conv1d_ctrl_fsm;
  import conv1d_ctrl_pkg::*;
  localparam int MAC_LAT = 1;
  logic clk_i = 1'b0;
  logic rst_i, start_i, clear_i, out_ready_i;
  len_t len_i;
  ksize_t ksize_i;
  len_t in_addr_o, out_addr_o;
  ksize_t w_addr_o;
  logic mac_en_o, mac_clr_o, mac_last_o, out_valid_o;
  logic running_o, running_we_o, done_o, done_we_o;
  logic [47:0] all_o;
  assign all_o = {mac_en_o, mac_clr_o, mac_last_o, out_valid_o, running_o, running_we_o,
                  done_o, done_we_o, in_addr_o, w_addr_o, out_addr_o};

  conv1d_ctrl_fsm #(.LEN_W(16), .K_W(8), .MAC_LAT(MAC_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .clear_i(clear_i),
    .len_i(len_i), .ksize_i(ksize_i), .in_addr_o(in_addr_o), .w_addr_o(w_addr_o),
    .mac_en_o(mac_en_o), .mac_clr_o(mac_clr_o), .mac_last_o(mac_last_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_addr_o(out_addr_o),
    .running_o(running_o), .running_we_o(running_we_o), .done_o(done_o), .done_we_o(done_we_o)
  );

  always #5 clk_i = ~clk_i;

  int vec = 0, errs = 0;
  int exp_mac[$], exp_out[$], obs_mac[$], obs_out[$];
  int run_c, done_c, run_cnt, done_cnt, stall_cyc, hold_bad, clr_c, post_act, bad_pair;
  logic [3:0] clr_snap;

  // expected tap tuples {in_addr, w_addr, clr, last} and output indices straight from the loop nest
  function automatic void model(input int n, input int k);
    exp_mac.delete();
    exp_out.delete();
    if (k == 0 || k > n) return;
    for (int j = 0; j <= n - k; j++) begin
      exp_out.push_back(j);
      for (int t = 0; t < k; t++)
        exp_mac.push_back(((j + t) << 10) | (t << 2) | (int'(t == 0) << 1) | int'(t == k - 1));
    end
  endfunction

  function automatic int busy(input int n, input int k);
    return (k == 0 || k > n) ? 1 : (n - k + 1) * (k + MAC_LAT + 1);
  endfunction

  task automatic collect(input int n, input int k, input int stall_idx, input int stall_len,
                         input int rdy_pct, input int clr_idx, input bit hold, input int cycles);
    int stall_left = stall_len;
    int last_addr = -1;
    bit cleared = 0;
    obs_mac.delete();
    obs_out.delete();
    run_c = -1; done_c = -1; run_cnt = 0; done_cnt = 0; stall_cyc = 0;
    hold_bad = 0; clr_c = -1; post_act = 0; bad_pair = 0; clr_snap = '0;
    start_i = 0; clear_i = 0; out_ready_i = 1;
    @(negedge clk_i);
    len_i = len_t'(n);
    ksize_i = ksize_t'(k);
    start_i = 1;
    for (int c = 1; c <= cycles; c++) begin
      @(negedge clk_i);
      start_i = hold ? (c != 3) : 1'b0;
      clear_i = 0;
      if (running_we_o && running_o) begin run_cnt++; if (run_c < 0) run_c = c; end
      if (done_we_o && done_o) begin done_cnt++; if (done_c < 0) done_c = c; end
      if (done_we_o && !running_we_o) bad_pair++;
      if (clr_c > 0 && c == clr_c + 1)
        clr_snap = {running_we_o, running_o, done_we_o, mac_en_o | out_valid_o};
      else if (clr_c > 0 && c > clr_c + 1 && (running_we_o | done_we_o | mac_en_o | out_valid_o))
        post_act++;
      if (mac_en_o)
        obs_mac.push_back((int'(in_addr_o) << 10) | (int'(w_addr_o) << 2) |
                          (int'(mac_clr_o) << 1) | int'(mac_last_o));
      if (mac_en_o && out_valid_o) hold_bad++;
      out_ready_i = ($urandom_range(99) < rdy_pct);
      if (out_valid_o) begin
        if (obs_out.size() == stall_idx && stall_left > 0) begin out_ready_i = 0; stall_left--; end
        if (last_addr >= 0 && int'(out_addr_o) != last_addr) hold_bad++;
        if (out_ready_i) begin obs_out.push_back(int'(out_addr_o)); last_addr = -1; end
        else begin stall_cyc++; last_addr = int'(out_addr_o); end
      end else if (last_addr >= 0) begin
        hold_bad++;
        last_addr = -1;
      end
      if (clr_idx >= 0 && !cleared && mac_en_o && obs_out.size() == clr_idx) begin
        clear_i = 1; cleared = 1; clr_c = c;
      end
    end
    start_i = 0; clear_i = 0; out_ready_i = 1;
  endtask

  task automatic test_reset();
    rst_i = 1; start_i = 0; clear_i = 0; out_ready_i = 1; len_i = '0; ksize_i = '0;
    repeat (3) @(negedge clk_i);
    vec++; if (all_o !== '0) begin errs++; $display("FAIL reset_outputs got %h want 0", all_o); end
    rst_i = 0;
    @(negedge clk_i);
    vec++; if (all_o !== '0) begin errs++; $display("FAIL idle_outputs got %h want 0", all_o); end
    len_i = 8; ksize_i = 3; start_i = 1;
    repeat (7) @(negedge clk_i);
    start_i = 0;
    vec++; if (!(mac_en_o | out_valid_o)) begin errs++; $display("FAIL run_before_rst got idle want busy"); end
    rst_i = 1;
    @(negedge clk_i);
    rst_i = 0;
    vec++; if (all_o !== '0) begin errs++; $display("FAIL midrun_rst got %h want 0", all_o); end
    repeat (3) begin
      @(negedge clk_i);
      vec++; if (all_o !== '0) begin errs++; $display("FAIL after_rst_quiet got %h want 0", all_o); end
    end
  endtask

  task automatic test_basic();
    collect(8, 3, -1, 0, 100, -1, 0, 45);
    model(8, 3);
    vec++; if (obs_mac.size() != exp_mac.size()) begin errs++; $display("FAIL basic_taps got %0d want %0d", obs_mac.size(), exp_mac.size()); end
    for (int i = 0; i < exp_mac.size() && i < obs_mac.size(); i++) begin
      vec++; if (obs_mac[i] !== exp_mac[i]) begin errs++; $display("FAIL basic_tap[%0d] got %h want %h", i, obs_mac[i], exp_mac[i]); end
    end
    vec++; if (obs_out.size() != 6) begin errs++; $display("FAIL basic_nout got %0d want 6", obs_out.size()); end
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
      vec++; if (obs_out[i] != exp_out[i]) begin errs++; $display("FAIL basic_out[%0d] got %0d want %0d", i, obs_out[i], exp_out[i]); end
    end
    vec++; if (run_c != 1) begin errs++; $display("FAIL basic_run_pulse got %0d want 1", run_c); end
    vec++; if (done_c - run_c != 30) begin errs++; $display("FAIL basic_done_delay got %0d want 30", done_c - run_c); end
    vec++; if (run_cnt != 1 || done_cnt != 1 || bad_pair != 0) begin errs++; $display("FAIL basic_pulses got %0d/%0d/%0d want 1/1/0", run_cnt, done_cnt, bad_pair); end
  endtask

  task automatic test_backpressure();
    collect(4, 2, 1, 5, 100, -1, 0, 40);
    model(4, 2);
    vec++; if (done_c - run_c != busy(4, 2) + 5) begin errs++; $display("FAIL bp_len got %0d want %0d", done_c - run_c, busy(4, 2) + 5); end
    vec++; if (stall_cyc != 5 || hold_bad != 0) begin errs++; $display("FAIL bp_hold got stall=%0d bad=%0d want 5/0", stall_cyc, hold_bad); end
    vec++; if (obs_out.size() != 3) begin errs++; $display("FAIL bp_nout got %0d want 3", obs_out.size()); end
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
      vec++; if (obs_out[i] != exp_out[i]) begin errs++; $display("FAIL bp_out[%0d] got %0d want %0d", i, obs_out[i], exp_out[i]); end
    end
    vec++; if (obs_mac.size() != exp_mac.size()) begin errs++; $display("FAIL bp_taps got %0d want %0d", obs_mac.size(), exp_mac.size()); end
  endtask

  task automatic test_degenerate();
    int ks[3] = '{5, 0, 4};
    for (int t = 0; t < 3; t++) begin
      collect(4, ks[t], -1, 0, 100, -1, 0, 16);
      model(4, ks[t]);
      vec++; if (run_c != 1 || done_c - run_c != busy(4, ks[t])) begin errs++; $display("FAIL degen_k%0d_timing got run=%0d done=%0d want 1/%0d", ks[t], run_c, done_c, 1 + busy(4, ks[t])); end
      vec++; if (obs_out.size() != exp_out.size() || obs_mac.size() != exp_mac.size()) begin errs++; $display("FAIL degen_k%0d_count got out=%0d taps=%0d want %0d/%0d", ks[t], obs_out.size(), obs_mac.size(), exp_out.size(), exp_mac.size()); end
      for (int i = 0; i < exp_mac.size() && i < obs_mac.size(); i++) begin
        vec++; if (obs_mac[i] !== exp_mac[i]) begin errs++; $display("FAIL degen_k%0d_tap[%0d] got %h want %h", ks[t], i, obs_mac[i], exp_mac[i]); end
      end
      vec++; if (done_cnt != 1 || run_cnt != 1) begin errs++; $display("FAIL degen_k%0d_pulses got %0d/%0d want 1/1", ks[t], run_cnt, done_cnt); end
    end
  endtask

  task automatic test_clear();
    collect(8, 3, -1, 0, 100, 2, 0, 30);
    model(8, 3);
    vec++; if (clr_snap !== 4'b1000) begin errs++; $display("FAIL clear_pulse got %b want 1000", clr_snap); end
    vec++; if (post_act != 0 || done_cnt != 0) begin errs++; $display("FAIL clear_quiet got act=%0d done=%0d want 0/0", post_act, done_cnt); end
    vec++; if (obs_out.size() != 2 || obs_mac.size() != 7) begin errs++; $display("FAIL clear_progress got out=%0d taps=%0d want 2/7", obs_out.size(), obs_mac.size()); end
    for (int i = 0; i < obs_mac.size() && i < exp_mac.size(); i++) begin
      vec++; if (obs_mac[i] !== exp_mac[i]) begin errs++; $display("FAIL clear_tap[%0d] got %h want %h", i, obs_mac[i], exp_mac[i]); end
    end
    collect(8, 3, -1, 0, 100, -1, 0, 40);
    vec++; if (obs_mac.size() != exp_mac.size() || obs_out.size() != 6) begin errs++; $display("FAIL clear_rerun got taps=%0d out=%0d want %0d/6", obs_mac.size(), obs_out.size(), exp_mac.size()); end
    for (int i = 0; i < exp_mac.size() && i < obs_mac.size(); i++) begin
      vec++; if (obs_mac[i] !== exp_mac[i]) begin errs++; $display("FAIL clear_rerun_tap[%0d] got %h want %h", i, obs_mac[i], exp_mac[i]); end
    end
    vec++; if (done_c - run_c != 30) begin errs++; $display("FAIL clear_rerun_len got %0d want 30", done_c - run_c); end
  endtask

  task automatic test_hold_start();
    collect(4, 1, -1, 0, 100, -1, 1, 100);
    model(4, 1);
    vec++; if (run_cnt != 1 || done_cnt != 1) begin errs++; $display("FAIL hold_runs got %0d/%0d want 1/1", run_cnt, done_cnt); end
    vec++; if (obs_out.size() != 4) begin errs++; $display("FAIL hold_nout got %0d want 4", obs_out.size()); end
    for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
      vec++; if (obs_out[i] != exp_out[i]) begin errs++; $display("FAIL hold_out[%0d] got %0d want %0d", i, obs_out[i], exp_out[i]); end
    end
    vec++; if (done_c - run_c != busy(4, 1)) begin errs++; $display("FAIL hold_len got %0d want %0d", done_c - run_c, busy(4, 1)); end
  endtask

  task automatic test_start_clear();
    start_i = 0; clear_i = 0;
    @(negedge clk_i);
    len_i = 8; ksize_i = 3; start_i = 1; clear_i = 1;
    @(negedge clk_i);
    clear_i = 0;
    repeat (6) begin
      vec++; if (all_o !== '0) begin errs++; $display("FAIL start_clear got %h want 0", all_o); end
      @(negedge clk_i);
    end
    start_i = 0;
  endtask

  task automatic test_random();
    repeat (10) begin
      int n = $urandom_range(10, 1);
      int k = $urandom_range(n + 1, 0);
      collect(n, k, -1, 0, 70, -1, 0, 300);
      model(n, k);
      vec++; if (obs_mac.size() != exp_mac.size() || obs_out.size() != exp_out.size()) begin errs++; $display("FAIL rand_n%0d_k%0d_count got %0d/%0d want %0d/%0d", n, k, obs_mac.size(), obs_out.size(), exp_mac.size(), exp_out.size()); end
      for (int i = 0; i < exp_mac.size() && i < obs_mac.size(); i++) begin
        vec++; if (obs_mac[i] !== exp_mac[i]) begin errs++; $display("FAIL rand_n%0d_k%0d_tap[%0d] got %h want %h", n, k, i, obs_mac[i], exp_mac[i]); end
      end
      for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++) begin
        vec++; if (obs_out[i] != exp_out[i]) begin errs++; $display("FAIL rand_n%0d_k%0d_out[%0d] got %0d want %0d", n, k, i, obs_out[i], exp_out[i]); end
      end
      vec++; if (run_c != 1 || done_c - run_c != busy(n, k) + stall_cyc || done_cnt != 1 || hold_bad != 0) begin errs++; $display("FAIL rand_n%0d_k%0d_timing got run=%0d len=%0d done=%0d bad=%0d want 1/%0d/1/0", n, k, run_c, done_c - run_c, done_cnt, hold_bad, busy(n, k) + stall_cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_degenerate();
    test_clear();
    test_hold_start();
    test_start_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
